// File: rtl/nexys_starship_event_gen.sv
// nexys_starship_event_gen: LFSR-paced break-event scheduler for the four repair stations.
// Define NEXYS_STARSHIP_DIFFICULTY_RAMP_EN to shrink the random gap as events accumulate.
module nexys_starship_event_gen #(
    parameter int          NUM_STATIONS = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter logic [7:0]  MIN_GAP      = 8'd2,
    parameter logic [3:0]  GAP_MASK     = 4'hF
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    tick,
    input  logic                    play_flag,
    input  logic                    gameover_ctrl,
    input  logic [NUM_STATIONS-1:0] broken,
    output logic [NUM_STATIONS-1:0] station_random,
    output logic [3:0]              random_hex,
    output logic [7:0]              events_issued,
    output logic                    active
);
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        ARM  = 4'b0010,
        WAIT = 4'b0100,
        FIRE = 4'b1000
    } state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [7:0]  gap;
    logic [3:0]  mask;
    logic [8:0]  gap_sum;
    logic [1:0]  sel;
    logic        found;

`ifdef NEXYS_STARSHIP_DIFFICULTY_RAMP_EN
    assign mask = GAP_MASK >> ((events_issued[7:3] > 5'd4) ? 5'd4 : events_issued[7:3]);
`else
    assign mask = GAP_MASK;
`endif

    assign gap_sum = {1'b0, MIN_GAP} + {5'b0, lfsr[3:0] & mask};

    // Descending scan so the nearest free station after the candidate wins.
    always_comb begin
        found = 1'b0;
        sel   = lfsr[5:4];
        for (int k = 3; k >= 0; k--) begin
            if (!broken[lfsr[5:4] + 2'(k)]) begin
                found = 1'b1;
                sel   = lfsr[5:4] + 2'(k);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state          <= IDLE;
            lfsr           <= SEED;
            gap            <= 8'd0;
            station_random <= '0;
            random_hex     <= 4'h1;
            events_issued  <= 8'd0;
            active         <= 1'b0;
        end else begin
            lfsr           <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            station_random <= '0;
            if (gameover_ctrl && state != IDLE) begin
                state  <= IDLE;
                active <= 1'b0;
                gap    <= 8'd0;
            end else begin
                case (state)
                    IDLE: if (play_flag && !gameover_ctrl) begin
                        state         <= ARM;
                        active        <= 1'b1;
                        events_issued <= 8'd0;
                    end
                    ARM: begin
                        gap   <= gap_sum[8] ? 8'hFF : gap_sum[7:0];
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (tick && gap != 8'd0) gap <= gap - 8'd1;
                        if (gap == 8'd0 || (gap == 8'd1 && tick)) state <= FIRE;
                    end
                    FIRE: begin
                        state <= ARM;
                        if (found) begin
                            station_random[sel] <= 1'b1;
                            random_hex          <= (lfsr[11:8] == 4'h0) ? 4'h1 : lfsr[11:8];
                            events_issued       <= (events_issued == 8'hFF) ? 8'hFF : events_issued + 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_nexys_starship_event_gen.sv
// tb_nexys_starship_event_gen: directed self-checking bench for the break-event scheduler.
module tb_nexys_starship_event_gen;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       tick = 1'b0;
    logic       play_flag = 1'b0;
    logic       gameover_ctrl = 1'b0;
    logic [3:0] broken = 4'h0;
    logic [3:0] station_random;
    logic [3:0] random_hex;
    logic [7:0] events_issued;
    logic       active;

    int passed = 0;
    int total = 0;
    int exp_events = 0;
    logic [3:0] last_hex = 4'h1;
    logic [15:0] m;

    nexys_starship_event_gen dut (
        .Clk(Clk), .Reset(Reset), .tick(tick), .play_flag(play_flag),
        .gameover_ctrl(gameover_ctrl), .broken(broken),
        .station_random(station_random), .random_hex(random_hex),
        .events_issued(events_issued), .active(active)
    );

    always #5 Clk = ~Clk;

    // Reference LFSR, kept in lockstep with the design's free-running generator.
    always @(posedge Clk or posedge Reset)
        if (Reset) m <= 16'hACE1;
        else m <= (m >> 1) ^ (m[0] ? 16'hB400 : 16'h0000);

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Entered with the design in ARM; returns with it in ARM again (or IDLE for mode 3).
    // mode 0: nothing broken; 1: candidate..3 broken at FIRE; 2: all broken; 3: gameover at FIRE.
    task automatic run_event(input int mode, output int g, output logic [3:0] st, output logic [3:0] hx);
        int ticks, c, s;
        logic early;
        logic [3:0] msk, bf, exp_st;
        logic [15:0] mf;
        msk = 4'hF;
`ifdef NEXYS_STARSHIP_DIFFICULTY_RAMP_EN
        msk = 4'hF >> (((exp_events >> 3) > 4) ? 4 : (exp_events >> 3));
`endif
        g = 2 + int'(m[3:0] & msk);
        ticks = 0;
        early = 1'b0;
        tick = 1'b0;
        broken = (mode == 1 || mode == 2) ? 4'hF : 4'h0;
        step();
        chk("pulse_one_cycle", station_random, 4'h0);
        chk("hex_hold", random_hex, last_hex);
        for (int k = 0; ticks < g; k++) begin
            tick = (k % 4 == 0);
            step();
            if (tick) ticks++;
            if (station_random !== 4'h0 || random_hex !== last_hex) early = 1'b1;
        end
        tick = 1'b0;
        mf = m;
        c = int'(mf[5:4]);
        bf = broken;
        if (mode == 1) bf = (c == 0) ? 4'b0001 : ((4'hF << c) & 4'hF);
        broken = bf;
        if (mode == 3) gameover_ctrl = 1'b1;
        step();
        broken = 4'h0;
        gameover_ctrl = 1'b0;
        s = -1;
        for (int j = 0; j < 4; j++)
            if (s < 0 && !bf[(c + j) % 4]) s = (c + j) % 4;
        exp_st = 4'h0;
        if (mode != 3 && s >= 0) begin
            exp_st = 4'h1 << s;
            if (exp_events < 255) exp_events++;
            last_hex = (mf[11:8] == 4'h0) ? 4'h1 : mf[11:8];
        end
        chk("no_early_pulse", early, 1'b0);
        chk("station", station_random, exp_st);
        chk("hex", random_hex, last_hex);
        chk("events", events_issued, exp_events);
        chk("active", active, (mode == 3) ? 1'b0 : 1'b1);
        st = station_random;
        hx = random_hex;
    endtask

    task automatic start_game();
        Reset = 1'b0;
        step();
        step();
        chk("idle_active", active, 1'b0);
        play_flag = 1'b1;
        step();
        play_flag = 1'b0;
        exp_events = 0;
        chk("arm_active", active, 1'b1);
        chk("arm_events", events_issued, 8'd0);
    endtask

    initial begin
        int g, g1, gmin, gmax;
        logic [3:0] st, hx, st1, hx1;
        step();
        step();
        chk("rst_station", station_random, 4'h0);
        chk("rst_hex", random_hex, 4'h1);
        chk("rst_events", events_issued, 8'd0);
        chk("rst_active", active, 1'b0);
        start_game();
        run_event(0, g1, st1, hx1);
        chk("first_onehot", $countones(st1), 1);
        chk("first_hex_nz", hx1 != 4'h0, 1'b1);
        repeat (2) run_event(0, g, st, hx);
        repeat (4) run_event(1, g, st, hx);
        repeat (3) run_event(2, g, st, hx);
        run_event(3, g, st, hx);
        step();
        chk("go_idle_active", active, 1'b0);
        chk("go_events_hold", events_issued, exp_events);
        play_flag = 1'b1;
        gameover_ctrl = 1'b1;
        step();
        gameover_ctrl = 1'b0;
        chk("play_go_idle", active, 1'b0);
        step();
        play_flag = 1'b0;
        exp_events = 0;
        chk("replay_active", active, 1'b1);
        chk("replay_events", events_issued, 8'd0);
        run_event(0, g, st, hx);
        // Async reset mid-WAIT, then a fresh start must repeat the first event.
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        Reset = 1'b1;
        #2;
        chk("arst_station", station_random, 4'h0);
        chk("arst_hex", random_hex, 4'h1);
        chk("arst_events", events_issued, 8'd0);
        chk("arst_active", active, 1'b0);
        step();
        step();
        last_hex = 4'h1;
        start_game();
        run_event(0, g, st, hx);
        chk("repeat_gap", g, g1);
        chk("repeat_station", st, st1);
        chk("repeat_hex", hx, hx1);
        gmin = 99;
        gmax = 0;
        repeat (40) begin
            run_event(0, g, st, hx);
            if (g < gmin) gmin = g;
            if (g > gmax) gmax = g;
        end
        chk("gap_range", gmin >= 2 && gmax <= 17, 1'b1);
`ifdef NEXYS_STARSHIP_DIFFICULTY_RAMP_EN
        chk("ramp_final_gap", g, 2);
`else
        chk("gap_varies", gmin != gmax, 1'b1);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
